// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: read-side controller for a first-word-fall-through FIFO.
// Waits until a full burst is stored, then drains exactly that many words into a
// registered valid/ready stream and tags the final word of each burst with out_last.
// A flush request lets a short final burst go out.
//
// Handshake: a word moves downstream on every rising edge where out_valid and
// out_ready are both 1. While out_valid=1 and out_ready=0, out_data and out_last
// hold their values. The FIFO side works the same way: fifo_read=1 pops the head
// word at the next edge. fifo_read is only raised while the output register is
// empty or being emptied in the same cycle.
//
// FSM state is visible externally through busy: busy=1 while in BURST or while
// a word waits in the output register.

module fifo_burst_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int BURST_LEN  = 4
) (
   input  logic                              clk,
   input  logic                              rst_n,
   output logic                              fifo_read,
   input  logic [DATA_WIDTH-1:0]             fifo_read_data,
   input  logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_fill_level,
   input  logic                              fifo_empty,
   input  logic                              flush,
   output logic                              out_valid,
   output logic [DATA_WIDTH-1:0]             out_data,
   output logic                              out_last,
   input  logic                              out_ready,
   output logic                              busy,
   output logic [15:0]                       bursts_done
);

   localparam int FILL_W = $clog2(FIFO_DEPTH+1);
   localparam int REM_W  = $clog2(BURST_LEN+1);
   localparam logic [FILL_W-1:0] BURST_FILL = FILL_W'(BURST_LEN);
   localparam logic [REM_W-1:0]  BURST_REM  = REM_W'(BURST_LEN);

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [REM_W-1:0]        remaining_q, remaining_d;
   logic                    flush_pending_q, flush_pending_d;
   logic                    out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
   logic                    out_last_q, out_last_d;
   logic [15:0]             bursts_done_q, bursts_done_d;
   logic                    pop;
   logic                    start;

   // Next-state, pop strobe and output-register updates.
   always_comb begin
      state_d         = state_q;
      remaining_d     = remaining_q;
      flush_pending_d = flush_pending_q;
      out_valid_d     = out_valid_q;
      out_data_d      = out_data_q;
      out_last_d      = out_last_q;
      bursts_done_d   = bursts_done_q;
      pop             = 1'b0;
      start           = 1'b0;

      // A stored word leaves when downstream takes it and nothing refills the register.
      pop = (state_q == BURST) && (remaining_q != '0) && (!out_valid_q || out_ready);

      if (out_valid_q && out_ready && !pop) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end

      if (out_valid_q && out_ready && out_last_q) begin
         bursts_done_d = bursts_done_q + 16'd1;
      end

      unique case (state_q)
         IDLE: begin
            start = (fifo_fill_level >= BURST_FILL) || (flush_pending_q && !fifo_empty);
            if (start) begin
               state_d = BURST;
               // A short burst is only possible while a flush is pending.
               if (fifo_fill_level < BURST_FILL) begin
                  remaining_d = REM_W'(fifo_fill_level);
               end else begin
                  remaining_d = BURST_REM;
               end
               // This burst takes everything stored, so the flush is satisfied.
               if (fifo_fill_level <= BURST_FILL) begin
                  flush_pending_d = 1'b0;
               end
            end else if (fifo_empty) begin
               flush_pending_d = 1'b0;
            end
         end
         BURST: begin
            if (pop) begin
               out_data_d  = fifo_read_data;
               out_valid_d = 1'b1;
               out_last_d  = (remaining_q == REM_W'(1));
               remaining_d = remaining_q - REM_W'(1);
               // Return to IDLE right away so the next burst can start while
               // the last word still waits in the output register.
               if (remaining_q == REM_W'(1)) begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A new flush request always wins over a same-cycle clear.
      if (flush) begin
         flush_pending_d = 1'b1;
      end
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         remaining_q     <= '0;
         flush_pending_q <= 1'b0;
         out_valid_q     <= 1'b0;
         out_data_q      <= '0;
         out_last_q      <= 1'b0;
         bursts_done_q   <= '0;
      end else begin
         state_q         <= state_d;
         remaining_q     <= remaining_d;
         flush_pending_q <= flush_pending_d;
         out_valid_q     <= out_valid_d;
         out_data_q      <= out_data_d;
         out_last_q      <= out_last_d;
         bursts_done_q   <= bursts_done_d;
      end
   end

   assign fifo_read   = pop;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign out_last    = out_last_q;
   assign bursts_done = bursts_done_q;
   assign busy        = (state_q == BURST) || out_valid_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Testbench for fifo_burst_reader. The FIFO is modelled as a queue inside the bench;
// the expected output stream is built by cutting the written word sequence into
// groups of BURST_LEN, with a flush closing whatever partial group is open.

module tb_fifo_burst_reader;

   localparam int DW = 8;
   localparam int DEPTH = 16;
   localparam int BL = 4;
   localparam int FW = $clog2(DEPTH+1);

   logic            clk;
   logic            rst_n;
   logic            fifo_read;
   logic [DW-1:0]   fifo_read_data;
   logic [FW-1:0]   fifo_fill_level;
   logic            fifo_empty;
   logic            flush;
   logic            out_valid;
   logic [DW-1:0]   out_data;
   logic            out_last;
   logic            out_ready;
   logic            busy;
   logic [15:0]     bursts_done;

   fifo_burst_reader #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .BURST_LEN(BL)) dut (
      .clk(clk), .rst_n(rst_n), .fifo_read(fifo_read), .fifo_read_data(fifo_read_data),
      .fifo_fill_level(fifo_fill_level), .fifo_empty(fifo_empty), .flush(flush),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
      .out_ready(out_ready), .busy(busy), .bursts_done(bursts_done)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bench state: FIFO contents, open group, expected stream {last,data}
   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] grp_q[$];
   logic [DW:0]   exp_q[$];
   int            hs_cyc_q[$];
   logic [15:0]   exp_bursts;
   int            n_checks;
   int            n_fail;
   int            cyc;
   int            ready_mode;   // 0: always 1, 1: toggle, 2: random
   logic          prev_stall;
   logic [DW-1:0] prev_data;
   logic          prev_last;

   // ---------------- FIFO and reference model ----------------
   task automatic update_ports();
      fifo_fill_level = FW'(fifo_q.size());
      fifo_empty      = (fifo_q.size() == 0);
      fifo_read_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
   endtask

   task automatic close_group();
      for (int i = 0; i < grp_q.size(); i++) begin
         exp_q.push_back({(i == grp_q.size() - 1), grp_q[i]});
      end
      grp_q.delete();
   endtask

   task automatic push_word(input logic [DW-1:0] d);
      fifo_q.push_back(d);
      grp_q.push_back(d);
      if (grp_q.size() == BL) close_group();
      update_ports();
   endtask

   // One clock cycle: observe at negedge, apply FIFO pop and new inputs after posedge.
   task automatic step();
      logic        pop;
      logic [DW:0] e;
      @(negedge clk);
      pop = fifo_read;
      n_checks++;
      if (fifo_read && fifo_empty) begin
         n_fail++;
         $display("FAIL fifo_safety: fifo_read=%0b while fifo_empty=%0b (cycle %0d)", fifo_read, fifo_empty, cyc);
      end
      n_checks++;
      if (fifo_read && out_valid && !out_ready) begin
         n_fail++;
         $display("FAIL pop_while_stalled: fifo_read=1 with out_valid=1 out_ready=0 (cycle %0d)", cyc);
      end
      if (prev_stall) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
            n_fail++;
            $display("FAIL stall_hold: got valid=%0b data=%h last=%0b, expected valid=1 data=%h last=%0b",
                     out_valid, out_data, out_last, prev_data, prev_last);
         end
      end
      if (out_valid && out_ready) begin
         n_checks++;
         hs_cyc_q.push_back(cyc);
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL stream: unexpected word data=%h last=%0b, expected none", out_data, out_last);
         end else begin
            e = exp_q.pop_front();
            if (e[DW]) exp_bursts++;
            if ({out_last, out_data} !== e) begin
               n_fail++;
               $display("FAIL stream: got data=%h last=%0b, expected data=%h last=%0b",
                        out_data, out_last, e[DW-1:0], e[DW]);
            end
         end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      cyc++;
      @(posedge clk);
      #1;
      if (pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
      case (ready_mode)
         1: out_ready = !out_ready;
         2: out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b1;
      endcase
      update_ports();
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      close_group();
      step();
      flush = 1'b0;
   endtask

   // Run until the expected stream is empty and the reader is idle.
   task automatic drain(input string name, input int max_cycles);
      int i;
      for (i = 0; i < max_cycles; i++) begin
         step();
         if (exp_q.size() == 0 && !busy && fifo_q.size() == grp_q.size()) break;
      end
      step();
      step();
      n_checks++;
      if (i == max_cycles || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drain: %0d words still expected after %0d cycles, expected 0", name, exp_q.size(), i);
      end
   endtask

   task automatic check_bursts(input string name);
      n_checks++;
      if (bursts_done !== exp_bursts) begin
         n_fail++;
         $display("FAIL %s_bursts_done: got %0d, expected %0d", name, bursts_done, exp_bursts);
      end
   endtask

   // ---------------- Tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({out_valid, out_data, out_last, fifo_read, busy, bursts_done} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got valid=%0b data=%h last=%0b read=%0b busy=%0b bursts=%0d, expected all 0",
                  out_valid, out_data, out_last, fifo_read, busy, bursts_done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_single_burst();
      int k;
      ready_mode = 0;
      out_ready = 1'b1;
      hs_cyc_q.delete();
      step();
      k = cyc;
      for (int i = 0; i < 4; i++) push_word(8'hA0 + 8'(i));
      drain("single", 40);
      n_checks++;
      if (hs_cyc_q.size() != 4) begin
         n_fail++;
         $display("FAIL single_count: got %0d handshakes, expected 4", hs_cyc_q.size());
      end else begin
         if (hs_cyc_q[0] != k + 2 || hs_cyc_q[3] != hs_cyc_q[0] + 3) begin
            n_fail++;
            $display("FAIL single_timing: first word cycle %0d last %0d, expected %0d and %0d",
                     hs_cyc_q[0], hs_cyc_q[3], k + 2, k + 5);
         end
      end
      check_bursts("single");
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_busy: got %0b, expected 0", busy);
      end
   endtask

   task automatic test_flush_short();
      for (int i = 0; i < 3; i++) push_word(8'hB0 + 8'(i));
      for (int i = 0; i < 20; i++) begin
         step();
         n_checks++;
         if (out_valid !== 1'b0 || fifo_read !== 1'b0) begin
            n_fail++;
            $display("FAIL partial_hold: got valid=%0b read=%0b, expected 0 0", out_valid, fifo_read);
         end
      end
      pulse_flush();
      drain("flush_short", 40);
      check_bursts("flush_short");
      // A cleared flush must not release a new partial group.
      for (int i = 0; i < 2; i++) push_word(8'hC0 + 8'(i));
      for (int i = 0; i < 15; i++) begin
         step();
         n_checks++;
         if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_cleared: got valid=%0b, expected 0", out_valid);
         end
      end
      pulse_flush();
      drain("flush_short2", 40);
      check_bursts("flush_short2");
   endtask

   task automatic test_flush_split();
      for (int i = 0; i < 10; i++) push_word(8'h10 + 8'(i));
      pulse_flush();
      drain("split", 80);
      check_bursts("split");
   endtask

   task automatic test_stall_toggle();
      ready_mode = 1;
      for (int i = 0; i < 8; i++) push_word(8'h50 + 8'(i));
      drain("stall", 100);
      check_bursts("stall");
      ready_mode = 0;
      out_ready = 1'b1;
   endtask

   task automatic test_reset_mid_burst();
      int n;
      hs_cyc_q.delete();
      for (int i = 0; i < 4; i++) push_word(8'h70 + 8'(i));
      n = 0;
      while (hs_cyc_q.size() < 2 && n < 30) begin
         step();
         n++;
      end
      n_checks++;
      if (hs_cyc_q.size() < 2) begin
         n_fail++;
         $display("FAIL midrst_progress: got %0d handshakes, expected 2", hs_cyc_q.size());
      end
      #1;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({out_valid, out_data, out_last, fifo_read, busy, bursts_done} !== '0) begin
         n_fail++;
         $display("FAIL midrst_outputs: got valid=%0b data=%h last=%0b read=%0b busy=%0b bursts=%0d, expected all 0",
                  out_valid, out_data, out_last, fifo_read, busy, bursts_done);
      end
      exp_q.delete();
      grp_q = fifo_q;
      exp_bursts = '0;
      prev_stall = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         n_checks++;
         if (fifo_read !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_idle: got read=%0b valid=%0b, expected 0 0", fifo_read, out_valid);
         end
      end
      while (grp_q.size() != 0) push_word(8'h80 + 8'(grp_q.size()));
      drain("midrst", 40);
      check_bursts("midrst");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 16; i++) push_word(8'(i * 3 + 1));
      drain("full", 120);
      check_bursts("full");
   endtask

   task automatic test_random();
      logic [DW-1:0] d;
      ready_mode = 2;
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 39) == 0) begin
            pulse_flush();
            drain("rand_flush", 200);
         end else begin
            if ($urandom_range(0, 2) != 0 && fifo_q.size() < DEPTH) begin
               d = 8'($urandom_range(0, 255));
               push_word(d);
            end
            step();
         end
      end
      pulse_flush();
      drain("rand_end", 300);
      check_bursts("random");
      ready_mode = 0;
      out_ready = 1'b1;
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      cyc = 0;
      ready_mode = 0;
      exp_bursts = '0;
      prev_stall = 1'b0;
      prev_data = '0;
      prev_last = 1'b0;
      rst_n = 1'b0;
      flush = 1'b0;
      out_ready = 1'b1;
      update_ports();

      test_reset();
      test_single_burst();
      test_flush_short();
      test_flush_split();
      test_stall_toggle();
      test_reset_mid_burst();
      test_back_to_back();
      test_random();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
